// File: rtl/seq_alu.sv
// Registered multi-cycle word ALU: AND/OR/ADD/SUB/SLT/NOR, plus optional shift-add MUL (SEQ_ALU_MUL_EN).
// Latency: 1 cycle after accept for logic/arith/illegal ops, WIDTH cycles for MUL; done_o pulses once.
// Backpressure: start_i is only sampled in IDLE (busy_o=0); requests while busy are dropped, not queued.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CW     = $clog2(WIDTH) + 1;
`endif

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [WIDTH-1:0] ex_res;
    logic             ex_cout;
    logic             ex_ovf;
    logic             ex_err;
    logic             start_mul;

    // SUB and SLT share the adder as A + ~B + 1; SLT uses sign XOR overflow so it holds at the extremes.
    always_comb begin
        is_sub  = (op_q == OP_SUB) || (op_q == OP_SLT);
        b_eff   = is_sub ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        add_ovf = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        ex_res  = '0;
        ex_cout = 1'b0;
        ex_ovf  = 1'b0;
        ex_err  = 1'b0;
        case (op_q)
            OP_AND: ex_res = a_q & b_q;
            OP_OR:  ex_res = a_q | b_q;
            OP_NOR: ex_res = ~(a_q | b_q);
            OP_ADD, OP_SUB: begin
                ex_res  = sum[WIDTH-1:0];
                ex_cout = sum[WIDTH];
                ex_ovf  = add_ovf;
            end
            OP_SLT: begin
                ex_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
                ex_cout = sum[WIDTH];
            end
            default: ex_err = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_lo;
    logic [CW-1:0]    mul_cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;

    // One shift-add step: conditionally add A into the high half, then shift {carry, acc, lo} right.
    always_comb begin
        mul_sum                   = {1'b0, mul_acc} + (mul_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        {mul_acc_nxt, mul_lo_nxt} = {mul_sum, mul_lo[WIDTH-1:1]};
    end

    assign start_mul = (op_i == OP_MUL);
    assign hi_o      = hi_q;
`else
    assign start_mul = 1'b0;
    assign hi_o      = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
            err_o      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            hi_q       <= '0;
            mul_acc    <= '0;
            mul_lo     <= '0;
            mul_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        op_q   <= op_i;
                        a_q    <= src1_i;
                        b_q    <= src2_i;
                        busy_o <= 1'b1;
`ifdef SEQ_ALU_MUL_EN
                        mul_acc <= '0;
                        mul_lo  <= src2_i;
                        mul_cnt <= '0;
                        state   <= start_mul ? S_MUL : S_EXEC;
`else
                        state   <= start_mul ? S_DONE : S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    result_o   <= ex_res;
                    zero_o     <= (ex_res == '0);
                    cout_o     <= ex_cout;
                    overflow_o <= ex_ovf;
                    err_o      <= ex_err;
`ifdef SEQ_ALU_MUL_EN
                    hi_q       <= '0;
`endif
                    done_o     <= 1'b1;
                    state      <= S_DONE;
                end
`ifdef SEQ_ALU_MUL_EN
                S_MUL: begin
                    mul_acc <= mul_acc_nxt;
                    mul_lo  <= mul_lo_nxt;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == CW'(WIDTH - 1)) begin
                        result_o   <= mul_lo_nxt;
                        hi_q       <= mul_acc_nxt;
                        zero_o     <= 1'b0;
                        cout_o     <= 1'b0;
                        overflow_o <= 1'b0;
                        err_o      <= 1'b0;
                        done_o     <= 1'b1;
                        state      <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a WIDTH=32 instance driven from a vector table and a WIDTH=8 instance
// for multiply, reset-abort and illegal-op sequences; expectations follow SEQ_ALU_MUL_EN if defined.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=32 instance
    logic        rst_n, start, busy, done, zero, cout, ovf, err;
    logic [3:0]  op;
    logic [31:0] a, b, res, hi;

    // WIDTH=8 instance
    logic        rst8_n, start8, busy8, done8, zero8, cout8, ovf8, err8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, res8, hi8;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op), .src1_i(a), .src2_i(b),
        .busy_o(busy), .done_o(done), .result_o(res), .hi_o(hi), .zero_o(zero),
        .cout_o(cout), .overflow_o(ovf), .err_o(err)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst8_n), .start_i(start8), .op_i(op8), .src1_i(a8), .src2_i(b8),
        .busy_o(busy8), .done_o(done8), .result_o(res8), .hi_o(hi8), .zero_o(zero8),
        .cout_o(cout8), .overflow_o(ovf8), .err_o(err8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the done edge.
    task automatic run32(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'b0101; a = ~x; b = ~y;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) chk({name, "_timeout"}, {63'd0, done}, 64'd1);
    endtask

    task automatic run8(input string name, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0; op8 = 4'b0101; a8 = ~x; b8 = ~y;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done8) chk({name, "_timeout"}, {63'd0, done8}, 64'd1);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vt[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dcnt;

        vt.push_back('{"add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{"add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{"sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1});
        vt.push_back('{"slt_neg",  4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{"slt_pos",  4'b0111, 32'h00000001, 32'h80000000, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{"and",      4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{"or",       4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{"nor",      4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{"sub_zero", 4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{"ill_0101", 4'b0101, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1});
`ifdef SEQ_ALU_MUL_EN
        vt.push_back('{"mul32",    4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32});
`else
        vt.push_back('{"ill_1000", 4'b1000, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1});
`endif
        vt.push_back('{"add_5_7",  4'b0010, 32'h00000005, 32'h00000007, 32'h0000000C, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});

        rst_n = 1'b0; rst8_n = 1'b0;
        start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #12;
        chk("rst32_flags", {58'd0, busy, done, zero, cout, ovf, err}, 64'd0);
        chk("rst32_res", {32'd0, res}, 64'd0);
        chk("rst32_hi", {32'd0, hi}, 64'd0);
        chk("rst8_all", {42'd0, busy8, done8, zero8, cout8, ovf8, err8, res8, hi8}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) begin
            run32(vt[i].name, vt[i].op, vt[i].a, vt[i].b, lat);
            chk($sformatf("%s_lat", vt[i].name), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("%s_res", vt[i].name), {32'd0, res}, {32'd0, vt[i].res});
            chk($sformatf("%s_hi", vt[i].name), {32'd0, hi}, {32'd0, vt[i].hi});
            chk($sformatf("%s_zcve", vt[i].name), {60'd0, zero, cout, ovf, err},
                {60'd0, vt[i].z, vt[i].c, vt[i].v, vt[i].e});
            @(posedge clk); #1;
            chk($sformatf("%s_idle", vt[i].name), {62'd0, busy, done}, 64'd0);
            chk($sformatf("%s_hold", vt[i].name), {32'd0, res}, {32'd0, vt[i].res});
        end

        // start held high: accept, done, DONE (not accepted), accept, ... period of 3 edges.
        start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd2;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_k%0d", k), {62'd0, busy, done}, {62'd0, (k % 3) != 2, (k % 3) == 1});
        end
        start = 1'b0;
        chk("b2b_res", {32'd0, res}, 64'd3);
        @(posedge clk); #1;

        // Reset while an operation is in flight aborts it without a done pulse.
`ifdef SEQ_ALU_MUL_EN
        start8 = 1'b1; op8 = 4'b1000; a8 = 8'h12; b8 = 8'h34;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`else
        start8 = 1'b1; op8 = 4'b0010; a8 = 8'h09; b8 = 8'h09;
        @(posedge clk); #1;
        start8 = 1'b0;
`endif
        chk("abort_busy", {63'd0, busy8}, 64'd1);
        rst8_n = 1'b0;
        #1;
        chk("abort_outs", {42'd0, busy8, done8, zero8, cout8, ovf8, err8, res8, hi8}, 64'd0);
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) rst8_n = 1'b1;
            dcnt += int'(done8);
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        run8("post_rst_add", 4'b0010, 8'd5, 8'd7, lat);
        chk("post_rst_lat", 64'(lat), 64'd1);
        chk("post_rst_res", {56'd0, res8}, 64'd12);
        @(posedge clk); #1;

`ifdef SEQ_ALU_MUL_EN
        // 0xFF*0xFF with a second start pulse mid-operation that must be ignored.
        start8 = 1'b1; op8 = 4'b1000; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h03; b8 = 8'h03;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) begin start8 = 1'b1; op8 = 4'b0010; end
            if (lat == 3) start8 = 1'b0;
        end
        chk("mul8_lat", 64'(lat), 64'd8);
        chk("mul8_prod", {48'd0, hi8, res8}, 64'hFE01);
        chk("mul8_flags", {60'd0, zero8, cout8, ovf8, err8}, 64'd0);
        @(posedge clk); #1;
        chk("mul8_idle", {62'd0, busy8, done8}, 64'd0);
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            dcnt += int'(done8);
        end
        chk("mul8_no_extra", 64'(dcnt), 64'd0);
        chk("mul8_hold", {48'd0, hi8, res8}, 64'hFE01);
`else
        run8("ill8_1000", 4'b1000, 8'hFF, 8'hFF, lat);
        chk("ill8_lat", 64'(lat), 64'd1);
        chk("ill8_res", {48'd0, hi8, res8}, 64'd0);
        chk("ill8_flags", {60'd0, zero8, cout8, ovf8, err8}, 64'b1001);
        @(posedge clk); #1;
        chk("ill8_idle", {62'd0, busy8, done8}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
